// File: rtl/vga_text_timing_gen.sv
// VGA timing and text-cell address generator running on a clock-enable pixel strobe.
// Cell coordinates and the char-map address are built incrementally and stay aligned with x_o/y_o.
module vga_text_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int CLK_DIV    = 5,
    parameter int GLYPH_W    = 8,
    parameter int GLYPH_H    = 16,
    parameter int PIPE_DELAY = 2,
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int COLS      = H_ACTIVE / GLYPH_W,
    localparam int ROWS      = V_ACTIVE / GLYPH_H
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    output logic                          pix_en_o,
    output logic [$clog2(H_TOTAL)-1:0]    x_o,
    output logic [$clog2(V_TOTAL)-1:0]    y_o,
    output logic [$clog2(COLS)-1:0]       col_o,
    output logic [$clog2(ROWS)-1:0]       row_o,
    output logic [$clog2(GLYPH_W)-1:0]    glyph_x_o,
    output logic [$clog2(GLYPH_H)-1:0]    glyph_y_o,
    output logic [$clog2(COLS*ROWS)-1:0]  addr_o,
    output logic                          active_o,
    output logic                          line_start_o,
    output logic                          frame_start_o,
    output logic                          hsync_o,
    output logic                          vsync_o,
    output logic                          de_o
);

    localparam int XW  = $clog2(H_TOTAL);
    localparam int YW  = $clog2(V_TOTAL);
    localparam int CW  = $clog2(COLS);
    localparam int RW  = $clog2(ROWS);
    localparam int GXW = $clog2(GLYPH_W);
    localparam int GYW = $clog2(GLYPH_H);
    localparam int AW  = $clog2(COLS * ROWS);
    localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0]  DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0]  X_LAST     = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0]  X_ACT      = XW'(H_ACTIVE);
    localparam logic [XW-1:0]  X_ACT_LAST = XW'(H_ACTIVE - 1);
    localparam logic [XW-1:0]  HS_START   = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0]  HS_END     = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [YW-1:0]  Y_LAST     = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0]  Y_ACT      = YW'(V_ACTIVE);
    localparam logic [YW-1:0]  Y_ACT_LAST = YW'(V_ACTIVE - 1);
    localparam logic [YW-1:0]  VS_START   = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0]  VS_END     = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [GXW-1:0] GX_LAST    = GXW'(GLYPH_W - 1);
    localparam logic [GYW-1:0] GY_LAST    = GYW'(GLYPH_H - 1);
    localparam logic [AW-1:0]  COLS_A     = AW'(COLS);

    logic [DW-1:0]  r_div;
    logic           r_pix_en;
    logic [XW-1:0]  r_x;
    logic [YW-1:0]  r_y;
    logic [CW-1:0]  r_col;
    logic [RW-1:0]  r_row;
    logic [GXW-1:0] r_gx;
    logic [GYW-1:0] r_gy;
    logic [AW-1:0]  r_row_base;
    logic [AW-1:0]  r_addr;
    logic           r_active;
    logic           r_line_start;
    logic           r_frame_start;
    logic           r_hs_raw;
    logic           r_vs_raw;

    logic [DW-1:0]  w_div_next;
    logic           w_pen_next;
    logic [XW-1:0]  w_x_next;
    logic [YW-1:0]  w_y_next;
    logic [CW-1:0]  w_col_next;
    logic [RW-1:0]  w_row_next;
    logic [GXW-1:0] w_gx_next;
    logic [GYW-1:0] w_gy_next;
    logic [AW-1:0]  w_rb_next;

    // Everything registered below is derived from the post-edge counter values, so
    // addr_o, strobes and raw syncs change on the same edge as x_o/y_o.
    always_comb begin
        w_pen_next = (r_div == DIV_LAST);
        w_div_next = w_pen_next ? '0 : r_div + 1'b1;
        w_x_next   = r_x;
        w_y_next   = r_y;
        w_col_next = r_col;
        w_row_next = r_row;
        w_gx_next  = r_gx;
        w_gy_next  = r_gy;
        w_rb_next  = r_row_base;
        if (r_pix_en) begin
            w_x_next = (r_x == X_LAST) ? '0 : r_x + 1'b1;
            if (r_x < X_ACT_LAST) begin
                if (r_gx == GX_LAST) begin
                    w_gx_next  = '0;
                    w_col_next = r_col + 1'b1;
                end else begin
                    w_gx_next = r_gx + 1'b1;
                end
            end else begin
                w_gx_next  = '0;
                w_col_next = '0;
            end
            if (r_x == X_LAST) begin
                w_y_next = (r_y == Y_LAST) ? '0 : r_y + 1'b1;
                if (r_y < Y_ACT_LAST) begin
                    if (r_gy == GY_LAST) begin
                        w_gy_next  = '0;
                        w_row_next = r_row + 1'b1;
                        w_rb_next  = r_row_base + COLS_A;
                    end else begin
                        w_gy_next = r_gy + 1'b1;
                    end
                end else begin
                    w_gy_next  = '0;
                    w_row_next = '0;
                    w_rb_next  = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_div         <= '0;
            r_pix_en      <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_gx          <= '0;
            r_gy          <= '0;
            r_row_base    <= '0;
            r_addr        <= '0;
            r_active      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_hs_raw      <= ~HSYNC_POL;
            r_vs_raw      <= ~VSYNC_POL;
        end else begin
            r_div         <= w_div_next;
            r_pix_en      <= w_pen_next;
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_col         <= w_col_next;
            r_row         <= w_row_next;
            r_gx          <= w_gx_next;
            r_gy          <= w_gy_next;
            r_row_base    <= w_rb_next;
            r_addr        <= w_rb_next + AW'(w_col_next);
            r_active      <= (w_x_next < X_ACT) && (w_y_next < Y_ACT);
            r_line_start  <= w_pen_next && (w_x_next == '0);
            r_frame_start <= w_pen_next && (w_x_next == '0) && (w_y_next == '0);
            r_hs_raw      <= (w_x_next >= HS_START && w_x_next <= HS_END) ? HSYNC_POL : ~HSYNC_POL;
            r_vs_raw      <= (w_y_next >= VS_START && w_y_next <= VS_END) ? VSYNC_POL : ~VSYNC_POL;
        end
    end

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign hsync_o = r_hs_raw;
            assign vsync_o = r_vs_raw;
            assign de_o    = r_active;
        end else begin : g_delay
            logic [PIPE_DELAY-1:0] r_hs_pipe;
            logic [PIPE_DELAY-1:0] r_vs_pipe;
            logic [PIPE_DELAY-1:0] r_de_pipe;

            // One stage per pixel period; the bench-facing outputs tap the last stage.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_hs_pipe <= {PIPE_DELAY{~HSYNC_POL}};
                    r_vs_pipe <= {PIPE_DELAY{~VSYNC_POL}};
                    r_de_pipe <= '0;
                end else if (r_pix_en) begin
                    r_hs_pipe[0] <= r_hs_raw;
                    r_vs_pipe[0] <= r_vs_raw;
                    r_de_pipe[0] <= r_active;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        r_hs_pipe[i] <= r_hs_pipe[i-1];
                        r_vs_pipe[i] <= r_vs_pipe[i-1];
                        r_de_pipe[i] <= r_de_pipe[i-1];
                    end
                end
            end

            assign hsync_o = r_hs_pipe[PIPE_DELAY-1];
            assign vsync_o = r_vs_pipe[PIPE_DELAY-1];
            assign de_o    = r_de_pipe[PIPE_DELAY-1];
        end
    endgenerate

    assign pix_en_o      = r_pix_en;
    assign x_o           = r_x;
    assign y_o           = r_y;
    assign col_o         = r_col;
    assign row_o         = r_row;
    assign glyph_x_o     = r_gx;
    assign glyph_y_o     = r_gy;
    assign addr_o        = r_addr;
    assign active_o      = r_active;
    assign line_start_o  = r_line_start;
    assign frame_start_o = r_frame_start;

endmodule

// File: tb/tb_vga_text_timing_gen.sv
// Bench for vga_text_timing_gen: three configurations checked every clock against an
// arithmetic model of elapsed clocks since reset release, plus directed timing points.
module tb_vga_text_timing_gen;

    typedef struct {
        int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, div, gw, gh, pd;
        bit hpol, vpol;
    } cfg_t;

    typedef struct {
        bit pen;
        int x, y, col, row, gx, gy, addr;
        bit act, ls, fs, hs, vs, de;
    } vals_t;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    always #5 clk = ~clk;

    // A: defaults. B: default geometry, one clock per pixel. C: small mode.
    logic a_pen, a_act, a_ls, a_fs, a_hs, a_vs, a_de;
    logic [9:0] a_x, a_y; logic [6:0] a_col; logic [4:0] a_row;
    logic [2:0] a_gx; logic [3:0] a_gy; logic [12:0] a_addr;
    logic b_pen, b_act, b_ls, b_fs, b_hs, b_vs, b_de;
    logic [9:0] b_x, b_y; logic [6:0] b_col; logic [4:0] b_row;
    logic [2:0] b_gx; logic [3:0] b_gy; logic [12:0] b_addr;
    logic c_pen, c_act, c_ls, c_fs, c_hs, c_vs, c_de;
    logic [4:0] c_x; logic [3:0] c_y; logic [1:0] c_col; logic [0:0] c_row;
    logic [1:0] c_gx; logic [1:0] c_gy; logic [2:0] c_addr;

    vga_text_timing_gen dut_a (
        .clk_i(clk), .rst_i(rst_a), .pix_en_o(a_pen), .x_o(a_x), .y_o(a_y),
        .col_o(a_col), .row_o(a_row), .glyph_x_o(a_gx), .glyph_y_o(a_gy), .addr_o(a_addr),
        .active_o(a_act), .line_start_o(a_ls), .frame_start_o(a_fs),
        .hsync_o(a_hs), .vsync_o(a_vs), .de_o(a_de));

    vga_text_timing_gen #(.CLK_DIV(1)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .pix_en_o(b_pen), .x_o(b_x), .y_o(b_y),
        .col_o(b_col), .row_o(b_row), .glyph_x_o(b_gx), .glyph_y_o(b_gy), .addr_o(b_addr),
        .active_o(b_act), .line_start_o(b_ls), .frame_start_o(b_fs),
        .hsync_o(b_hs), .vsync_o(b_vs), .de_o(b_de));

    vga_text_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(8), .V_FP(1), .V_SYNC(1),
        .V_BP(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(1), .GLYPH_W(4), .GLYPH_H(4),
        .PIPE_DELAY(0)
    ) dut_c (
        .clk_i(clk), .rst_i(rst_c), .pix_en_o(c_pen), .x_o(c_x), .y_o(c_y),
        .col_o(c_col), .row_o(c_row), .glyph_x_o(c_gx), .glyph_y_o(c_gy), .addr_o(c_addr),
        .active_o(c_act), .line_start_o(c_ls), .frame_start_o(c_fs),
        .hsync_o(c_hs), .vsync_o(c_vs), .de_o(c_de));

    int vectors = 0;
    int miscompares = 0;
    cfg_t ca, cb, cc;
    int ta, tbb, tc;

    task automatic check(input string inst, input string field, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s: observed %0d expected %0d", inst, field, obs, exp);
        end
    endtask

    // Expected outputs t clock edges after reset release (t=0: reset held).
    function automatic vals_t ref_model(input cfg_t c, input int t);
        vals_t e;
        int htot, vtot, n, nd, xd, yd;
        htot  = c.ha + c.hfp + c.hsw + c.hbp;
        vtot  = c.va + c.vfp + c.vsw + c.vbp;
        n     = (t >= 1) ? (t - 1) / c.div : 0;
        e.pen = (t >= c.div) && (t % c.div == 0);
        e.x   = n % htot;
        e.y   = (n / htot) % vtot;
        e.col = (e.x < c.ha) ? e.x / c.gw : 0;
        e.gx  = (e.x < c.ha) ? e.x % c.gw : 0;
        e.row = (e.y < c.va) ? e.y / c.gh : 0;
        e.gy  = (e.y < c.va) ? e.y % c.gh : 0;
        e.addr = e.row * (c.ha / c.gw) + e.col;
        e.act = (t > 0) && (e.x < c.ha) && (e.y < c.va);
        e.ls  = e.pen && (e.x == 0);
        e.fs  = e.ls && (e.y == 0);
        e.hs  = !c.hpol;
        e.vs  = !c.vpol;
        e.de  = 1'b0;
        nd = n - c.pd;
        if (t > 0 && nd >= 0) begin
            xd = nd % htot;
            yd = (nd / htot) % vtot;
            if (xd >= c.ha + c.hfp && xd < c.ha + c.hfp + c.hsw) e.hs = c.hpol;
            if (yd >= c.va + c.vfp && yd < c.va + c.vfp + c.vsw) e.vs = c.vpol;
            e.de = (xd < c.ha) && (yd < c.va);
        end
        return e;
    endfunction

    function automatic vals_t pk(input logic pen, input int x, input int y, input int col,
                                 input int row, input int gx, input int gy, input int addr,
                                 input logic act, input logic ls, input logic fs,
                                 input logic hs, input logic vs, input logic de);
        vals_t o;
        o.pen = pen; o.x = x; o.y = y; o.col = col; o.row = row; o.gx = gx; o.gy = gy;
        o.addr = addr; o.act = act; o.ls = ls; o.fs = fs; o.hs = hs; o.vs = vs; o.de = de;
        return o;
    endfunction

    task automatic cmp(input string nm, input cfg_t c, input int t, input vals_t o);
        vals_t e;
        e = ref_model(c, t);
        check(nm, "pix_en", int'(o.pen), int'(e.pen));
        check(nm, "x", o.x, e.x);
        check(nm, "y", o.y, e.y);
        check(nm, "col", o.col, e.col);
        check(nm, "row", o.row, e.row);
        check(nm, "glyph_x", o.gx, e.gx);
        check(nm, "glyph_y", o.gy, e.gy);
        check(nm, "addr", o.addr, e.addr);
        check(nm, "active", int'(o.act), int'(e.act));
        check(nm, "line_start", int'(o.ls), int'(e.ls));
        check(nm, "frame_start", int'(o.fs), int'(e.fs));
        check(nm, "hsync", int'(o.hs), int'(e.hs));
        check(nm, "vsync", int'(o.vs), int'(e.vs));
        check(nm, "de", int'(o.de), int'(e.de));
    endtask

    task automatic cmp_a();
        cmp("a", ca, ta, pk(a_pen, int'(a_x), int'(a_y), int'(a_col), int'(a_row), int'(a_gx),
            int'(a_gy), int'(a_addr), a_act, a_ls, a_fs, a_hs, a_vs, a_de));
    endtask
    task automatic cmp_b();
        cmp("b", cb, tbb, pk(b_pen, int'(b_x), int'(b_y), int'(b_col), int'(b_row), int'(b_gx),
            int'(b_gy), int'(b_addr), b_act, b_ls, b_fs, b_hs, b_vs, b_de));
    endtask
    task automatic cmp_c();
        cmp("c", cc, tc, pk(c_pen, int'(c_x), int'(c_y), int'(c_col), int'(c_row), int'(c_gx),
            int'(c_gy), int'(c_addr), c_act, c_ls, c_fs, c_hs, c_vs, c_de));
    endtask

    initial begin
        int a_last_ls, a_low_cnt, c_last_fs, b_hold, c_hold;
        bit a_first_done, a_prev_hs, b_cell_done, b_rst_done, b_wait, c_wait;

        ca = '{ha:640, hfp:16, hsw:96, hbp:48, va:480, vfp:10, vsw:2, vbp:33,
               div:5, gw:8, gh:16, pd:2, hpol:1'b0, vpol:1'b0};
        cb = ca;
        cb.div = 1;
        cc = '{ha:16, hfp:2, hsw:2, hbp:2, va:8, vfp:1, vsw:1, vbp:1,
               div:1, gw:4, gh:4, pd:0, hpol:1'b1, vpol:1'b1};
        a_last_ls = -1; a_low_cnt = 0; c_last_fs = -1; b_hold = 0; c_hold = 0;
        a_first_done = 1'b0; a_prev_hs = 1'b1; b_cell_done = 1'b0; b_rst_done = 1'b0;
        b_wait = 1'b0; c_wait = 1'b0;
        ta = 0; tbb = 0; tc = 0;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        repeat (3) @(negedge clk);
        cmp_a(); cmp_b(); cmp_c();
        check("a", "reset_hsync", int'(a_hs), 1);
        check("a", "reset_vsync", int'(a_vs), 1);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        for (int cyc = 1; cyc <= 41500; cyc++) begin
            @(posedge clk);
            if (!rst_a) ta++;
            if (!rst_b) tbb++;
            if (!rst_c) tc++;
            @(negedge clk);
            cmp_a(); cmp_b(); cmp_c();

            if (!a_first_done && a_pen) begin
                check("a", "first_pen_cycle", ta, 5);
                a_first_done = 1'b1;
            end
            if (a_pen && !a_hs) a_low_cnt++;
            if (a_ls) begin
                if (a_last_ls >= 0) check("a", "line_period", ta - a_last_ls, 4000);
                if (a_low_cnt > 0) check("a", "hsync_low_pixels", a_low_cnt, 96);
                a_last_ls = ta;
                a_low_cnt = 0;
            end
            if (!a_hs && a_prev_hs) check("a", "hsync_fall_x", int'(a_x), 658);
            if (a_hs && !a_prev_hs) check("a", "hsync_rise_x", int'(a_x), 754);
            a_prev_hs = a_hs;

            if (!b_cell_done && b_y == 10'd50 && b_x == 10'd17) begin
                check("b", "cell_row", int'(b_row), 3);
                check("b", "cell_glyph_y", int'(b_gy), 2);
                check("b", "cell_col", int'(b_col), 2);
                check("b", "cell_glyph_x", int'(b_gx), 1);
                check("b", "cell_addr", int'(b_addr), 242);
                b_cell_done = 1'b1;
            end
            if (b_wait && !rst_b && (b_ls || b_fs)) begin
                check("b", "first_strobe_is_frame", int'(b_fs), 1);
                b_wait = 1'b0;
            end

            if (c_pen && c_x == 5'd15 && c_y == 4'd7) check("c", "last_active_addr", int'(c_addr), 7);
            if (c_pen && (c_x == 5'd18 || c_x == 5'd19)) check("c", "hsync_high", int'(c_hs), 1);
            if (c_fs) begin
                if (c_last_fs >= 0) check("c", "frame_period", tc - c_last_fs, 242);
                c_last_fs = tc;
            end
            if (c_wait && !rst_c && (c_ls || c_fs)) begin
                check("c", "first_strobe_is_frame", int'(c_fs), 1);
                c_wait = 1'b0;
            end

            if (rst_b && b_hold > 0) begin
                b_hold--;
                if (b_hold == 0) rst_b = 1'b0;
            end
            if (rst_c && c_hold > 0) begin
                c_hold--;
                if (c_hold == 0) rst_c = 1'b0;
            end

            if (!b_rst_done && !rst_b && b_y == 10'd50 && b_x == 10'd100) begin
                rst_b = 1'b1;
                tbb = 0;
                #1;
                cmp_b();
                b_rst_done = 1'b1;
                b_hold = 3;
                b_wait = 1'b1;
            end
            if (!rst_c && cyc > 2000 && $urandom_range(299, 0) == 0) begin
                rst_c = 1'b1;
                tc = 0;
                c_last_fs = -1;
                #1;
                cmp_c();
                c_hold = int'($urandom_range(4, 1));
                c_wait = 1'b1;
            end
        end

        check("a", "first_pen_seen", int'(a_first_done), 1);
        check("b", "cell_point_reached", int'(b_cell_done), 1);
        check("b", "reset_point_reached", int'(b_rst_done), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
